// File: rtl/layer_argmax_8_16_if.sv
// Stream bus for the argmax classifier stage: activation words in, (max, index) result out.
interface layer_argmax_8_16_if #(
    parameter int unsigned T    = 16,
    parameter int unsigned LOGM = 4
);
    logic            s_valid;
    logic            s_ready;
    logic [T-1:0]    data_in;
    logic            m_valid;
    logic            m_ready;
    logic [T-1:0]    data_out;
    logic [LOGM-1:0] idx_out;

    modport slave (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, data_out, idx_out
    );

    modport master (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, data_out, idx_out
    );
endinterface

// File: rtl/layer_argmax_8_16.sv
// Argmax over each M-word vector of signed activations; emits the maximum and its row index.
module layer_argmax_8_16 #(
    parameter int unsigned M    = 8,
    parameter int unsigned T    = 16,
    parameter int unsigned LOGM = $clog2(M + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    layer_argmax_8_16_if.slave   bus
);
    typedef enum logic {
        ACCEPT = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    localparam logic [LOGM-1:0] LAST_IDX = LOGM'(M - 1);

    state_t          r_state;
    logic [LOGM-1:0] r_cnt;
    logic [T-1:0]    r_best_val;
    logic [LOGM-1:0] r_best_idx;
    logic            r_m_valid;
    logic [T-1:0]    r_data_out;
    logic [LOGM-1:0] r_idx_out;

    state_t          w_state_nxt;
    logic [LOGM-1:0] w_cnt_nxt;
    logic [T-1:0]    w_best_val_nxt;
    logic [LOGM-1:0] w_best_idx_nxt;
    logic            w_m_valid_nxt;
    logic [T-1:0]    w_data_out_nxt;
    logic [LOGM-1:0] w_idx_out_nxt;
    logic            w_take;
    logic            w_s_ready;

    // Next-state and datapath decode; the final word is folded into the result in the same cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_best_val_nxt = r_best_val;
        w_best_idx_nxt = r_best_idx;
        w_m_valid_nxt  = r_m_valid;
        w_data_out_nxt = r_data_out;
        w_idx_out_nxt  = r_idx_out;
        w_take         = 1'b0;
        w_s_ready      = 1'b0;

        unique case (r_state)
            ACCEPT: begin
                w_s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_take = (r_cnt == '0) || ($signed(bus.data_in) > $signed(r_best_val));
                    if (w_take) begin
                        w_best_val_nxt = bus.data_in;
                        w_best_idx_nxt = r_cnt;
                    end
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_nxt      = '0;
                        w_state_nxt    = OUTPUT;
                        w_m_valid_nxt  = 1'b1;
                        w_data_out_nxt = w_best_val_nxt;
                        w_idx_out_nxt  = w_best_idx_nxt;
                    end else begin
                        w_cnt_nxt = r_cnt + LOGM'(1);
                    end
                end
            end
            OUTPUT: begin
                if (bus.m_ready) begin
                    w_m_valid_nxt = 1'b0;
                    w_state_nxt   = ACCEPT;
                end
            end
            default: begin
                w_state_nxt = ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ACCEPT;
            r_cnt      <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_m_valid  <= 1'b0;
            r_data_out <= '0;
            r_idx_out  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_best_val <= w_best_val_nxt;
            r_best_idx <= w_best_idx_nxt;
            r_m_valid  <= w_m_valid_nxt;
            r_data_out <= w_data_out_nxt;
            r_idx_out  <= w_idx_out_nxt;
        end
    end

    // s_ready depends only on state and reset, never on s_valid or m_ready.
    assign bus.s_ready  = w_s_ready & reset;
    assign bus.m_valid  = r_m_valid;
    assign bus.data_out = r_data_out;
    assign bus.idx_out  = r_idx_out;
endmodule
